// File: rtl/sha256_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sha256_round_ctrl
// Description : Sequencer for a single-round SHA-256 compression core: block
//               handshake, init/64 rounds/feed-forward, K[t] ROM, chaining value.
// Revision    : 1.0 - initial release
// ============================================================================
module sha256_round_ctrl (
    input  logic         sys_clk,
    input  logic         rst,
    input  logic         blk_valid,
    input  logic         blk_last,
    output logic         blk_ready,
    input  logic         abort,
    output logic [5:0]   w_idx,
    output logic         core_init,
    output logic         core_en,
    output logic [31:0]  k_t,
    output logic [255:0] chain_h,
    input  logic [255:0] core_state,
    output logic [255:0] hash,
    output logic         hash_valid,
    input  logic         hash_ready
);

    localparam logic [255:0] IV = 256'h6A09E667_BB67AE85_3C6EF372_A54FF53A_510E527F_9B05688C_1F83D9AB_5BE0CD19;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_INIT  = 3'd1;
    localparam logic [2:0] S_ROUND = 3'd2;
    localparam logic [2:0] S_FOLD  = 3'd3;
    localparam logic [2:0] S_OUT   = 3'd4;

    logic [2:0]   state_q, state_d;
    logic [5:0]   rnd_q, rnd_d;
    logic         last_q, last_d;
    logic [255:0] chain_q, chain_d;

    function automatic logic [31:0] k_rom(input logic [5:0] idx);
        logic [31:0] k;
        case (idx)
            6'd0:  k = 32'h428A2F98;  6'd1:  k = 32'h71374491;
            6'd2:  k = 32'hB5C0FBCF;  6'd3:  k = 32'hE9B5DBA5;
            6'd4:  k = 32'h3956C25B;  6'd5:  k = 32'h59F111F1;
            6'd6:  k = 32'h923F82A4;  6'd7:  k = 32'hAB1C5ED5;
            6'd8:  k = 32'hD807AA98;  6'd9:  k = 32'h12835B01;
            6'd10: k = 32'h243185BE;  6'd11: k = 32'h550C7DC3;
            6'd12: k = 32'h72BE5D74;  6'd13: k = 32'h80DEB1FE;
            6'd14: k = 32'h9BDC06A7;  6'd15: k = 32'hC19BF174;
            6'd16: k = 32'hE49B69C1;  6'd17: k = 32'hEFBE4786;
            6'd18: k = 32'h0FC19DC6;  6'd19: k = 32'h240CA1CC;
            6'd20: k = 32'h2DE92C6F;  6'd21: k = 32'h4A7484AA;
            6'd22: k = 32'h5CB0A9DC;  6'd23: k = 32'h76F988DA;
            6'd24: k = 32'h983E5152;  6'd25: k = 32'hA831C66D;
            6'd26: k = 32'hB00327C8;  6'd27: k = 32'hBF597FC7;
            6'd28: k = 32'hC6E00BF3;  6'd29: k = 32'hD5A79147;
            6'd30: k = 32'h06CA6351;  6'd31: k = 32'h14292967;
            6'd32: k = 32'h27B70A85;  6'd33: k = 32'h2E1B2138;
            6'd34: k = 32'h4D2C6DFC;  6'd35: k = 32'h53380D13;
            6'd36: k = 32'h650A7354;  6'd37: k = 32'h766A0ABB;
            6'd38: k = 32'h81C2C92E;  6'd39: k = 32'h92722C85;
            6'd40: k = 32'hA2BFE8A1;  6'd41: k = 32'hA81A664B;
            6'd42: k = 32'hC24B8B70;  6'd43: k = 32'hC76C51A3;
            6'd44: k = 32'hD192E819;  6'd45: k = 32'hD6990624;
            6'd46: k = 32'hF40E3585;  6'd47: k = 32'h106AA070;
            6'd48: k = 32'h19A4C116;  6'd49: k = 32'h1E376C08;
            6'd50: k = 32'h2748774C;  6'd51: k = 32'h34B0BCB5;
            6'd52: k = 32'h391C0CB3;  6'd53: k = 32'h4ED8AA4A;
            6'd54: k = 32'h5B9CCA4F;  6'd55: k = 32'h682E6FF3;
            6'd56: k = 32'h748F82EE;  6'd57: k = 32'h78A5636F;
            6'd58: k = 32'h84C87814;  6'd59: k = 32'h8CC70208;
            6'd60: k = 32'h90BEFFFA;  6'd61: k = 32'hA4506CEB;
            6'd62: k = 32'hBEF9A3F7;  default: k = 32'hC67178F2;
        endcase
        return k;
    endfunction

    always_comb begin
        state_d = state_q;
        rnd_d   = rnd_q;
        last_d  = last_q;
        chain_d = chain_q;
        case (state_q)
            S_IDLE: begin
                if (blk_valid) begin
                    last_d  = blk_last;
                    state_d = S_INIT;
                end
            end
            S_INIT: begin
                rnd_d   = 6'd0;
                state_d = S_ROUND;
            end
            S_ROUND: begin
                // rnd wraps to 0 after round 63, so INIT/FOLD/IDLE all see w_idx=0
                rnd_d = rnd_q + 6'd1;
                if (rnd_q == 6'd63) begin
                    state_d = S_FOLD;
                end
            end
            S_FOLD: begin
                for (int i = 0; i < 8; i++) begin
                    chain_d[32*i +: 32] = chain_q[32*i +: 32] + core_state[32*i +: 32];
                end
                state_d = last_q ? S_OUT : S_IDLE;
            end
            S_OUT: begin
                if (hash_ready) begin
                    chain_d = IV;
                    last_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Abort overrides any handshake in the same cycle
        if (abort) begin
            state_d = S_IDLE;
            rnd_d   = 6'd0;
            last_d  = 1'b0;
            chain_d = IV;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            rnd_q   <= 6'd0;
            last_q  <= 1'b0;
            chain_q <= IV;
        end else begin
            state_q <= state_d;
            rnd_q   <= rnd_d;
            last_q  <= last_d;
            chain_q <= chain_d;
        end
    end

    assign blk_ready  = (state_q == S_IDLE);
    assign core_init  = (state_q == S_INIT);
    assign core_en    = (state_q == S_ROUND);
    assign hash_valid = (state_q == S_OUT);
    assign w_idx      = rnd_q;
    assign k_t        = k_rom(rnd_q);
    assign chain_h    = chain_q;
    assign hash       = chain_q;

endmodule
`default_nettype wire

// File: tb/tb_sha256_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sha256_round_ctrl
// Description : Self-checking bench with a behavioural SHA-256 core and schedule.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sha256_round_ctrl;

    localparam logic [255:0] C_IV  = 256'h6A09E667_BB67AE85_3C6EF372_A54FF53A_510E527F_9B05688C_1F83D9AB_5BE0CD19;
    localparam logic [255:0] C_ABC = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] C_TWO = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

    logic         sys_clk = 1'b0;
    logic         rst = 1'b1;
    logic         blk_valid = 1'b0;
    logic         blk_last = 1'b0;
    logic         abort = 1'b0;
    logic         hash_ready = 1'b0;
    logic         blk_ready, core_init, core_en, hash_valid;
    logic [5:0]   w_idx;
    logic [31:0]  k_t;
    logic [255:0] chain_h, hash;
    logic [255:0] cs = '0;

    logic [31:0]  blkw [16];
    logic [31:0]  wsched [64];
    logic [255:0] exp_q [$];
    int           vectors = 0;
    int           errs = 0;
    int           both_hi = 0;
    int           en_cnt;
    logic [31:0]  k63;

    always #5 sys_clk = ~sys_clk;

    sha256_round_ctrl dut (
        .sys_clk    (sys_clk),
        .rst        (rst),
        .blk_valid  (blk_valid),
        .blk_last   (blk_last),
        .blk_ready  (blk_ready),
        .abort      (abort),
        .w_idx      (w_idx),
        .core_init  (core_init),
        .core_en    (core_en),
        .k_t        (k_t),
        .chain_h    (chain_h),
        .core_state (cs),
        .hash       (hash),
        .hash_valid (hash_valid),
        .hash_ready (hash_ready)
    );

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] round_f(input logic [255:0] s, input logic [31:0] w, input logic [31:0] k);
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
        {a, b, c, d, e, f, g, h} = s;
        t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + k + w;
        t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
        return {t1 + t2, a, b, c, d + t1, e, f, g};
    endfunction

    // Behavioural compression core driven by the controller
    always @(posedge sys_clk) begin
        if (core_init)    cs <= chain_h;
        else if (core_en) cs <= round_f(cs, wsched[w_idx], k_t);
    end

    always @(negedge sys_clk) begin
        if (core_init && core_en) both_hi <= both_hi + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] expv);
        vectors++;
        assert (obs === expv) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic build_sched();
        logic [31:0] s0, s1;
        for (int t = 0; t < 16; t++) wsched[t] = blkw[t];
        for (int t = 16; t < 64; t++) begin
            s0 = ror(wsched[t-15], 7) ^ ror(wsched[t-15], 18) ^ (wsched[t-15] >> 3);
            s1 = ror(wsched[t-2], 17) ^ ror(wsched[t-2], 19) ^ (wsched[t-2] >> 10);
            wsched[t] = s1 + wsched[t-7] + s0 + wsched[t-16];
        end
    endtask

    task automatic set_abc();
        for (int i = 0; i < 16; i++) blkw[i] = 32'h0;
        blkw[0]  = 32'h61626380;
        blkw[15] = 32'h00000018;
    endtask

    task automatic send(input logic last);
        int waited;
        waited = 0;
        build_sched();
        blk_last  = last;
        blk_valid = 1'b1;
        while (!blk_ready && waited < 300) begin
            @(negedge sys_clk);
            waited++;
        end
        check("accept_timeout", 256'(waited >= 300), 256'd0);
        @(posedge sys_clk);
        #1 blk_valid = 1'b0;
    endtask

    task automatic wait_hv(output int k);
        k = 0;
        en_cnt = 0;
        k63 = '0;
        do begin
            @(negedge sys_clk);
            k++;
            if (core_en) en_cnt++;
            if (core_en && w_idx == 6'd63) k63 = k_t;
        end while (!hash_valid && k < 400);
    endtask

    task automatic wait_widx(input logic [5:0] idx);
        int k;
        k = 0;
        while (!(core_en && w_idx == idx) && k < 200) begin
            @(negedge sys_clk);
            k++;
        end
        check("reach_round", 256'(core_en && w_idx == idx), 256'd1);
    endtask

    task automatic take(input string tag);
        logic [255:0] e;
        e = 'x;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        hash_ready = 1'b1;
        check(tag, hash, e);
        @(posedge sys_clk);
        #1 hash_ready = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check(tag, {blk_ready, core_init, core_en, hash_valid, w_idx}, {4'b1000, 6'd0});
        check("reset_k_t", k_t, 32'h428A2F98);
        check("reset_hash", hash, C_IV);
    endtask

    initial begin
        int k;
        logic [255:0] h0;
        logic stable;

        repeat (3) @(posedge sys_clk);
        #1 rst = 1'b0;
        @(negedge sys_clk);
        check_reset_outputs("reset_ctrl");
        check("reset_chain", chain_h, C_IV);

        // Single block "abc"
        set_abc();
        exp_q.push_back(C_ABC);
        send(1'b1);
        wait_hv(k);
        check("abc_latency", k, 67);
        check("abc_en_cycles", en_cnt, 64);
        check("abc_k63", k63, 32'hC67178F2);
        take("abc_digest");
        @(negedge sys_clk);
        check("abc_chain_iv", chain_h, C_IV);

        // Two-block message
        blkw = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                 32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                 32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                 32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
        send(1'b0);
        k = 0;
        do begin
            @(negedge sys_clk);
            k++;
        end while (!blk_ready && k < 400);
        check("two_ready_latency", k, 67);
        for (int i = 0; i < 16; i++) blkw[i] = 32'h0;
        blkw[15] = 32'h000001c0;
        exp_q.push_back(C_TWO);
        send(1'b1);
        wait_hv(k);
        check("two_second_latency", k, 67);
        take("two_digest");

        // Backpressure with a held blk_valid for the next message
        set_abc();
        exp_q.push_back(C_ABC);
        send(1'b1);
        wait_hv(k);
        blk_valid = 1'b1;
        blk_last  = 1'b1;
        h0 = hash;
        stable = 1'b1;
        repeat (20) begin
            @(negedge sys_clk);
            if (hash !== h0 || !hash_valid || blk_ready) stable = 1'b0;
        end
        check("bp_stable", stable, 1'b1);
        exp_q.push_back(C_ABC);
        take("bp_digest");
        @(negedge sys_clk);
        check("bp_chain_iv", chain_h, C_IV);
        check("held_ready", blk_ready, 1'b1);
        @(posedge sys_clk);
        #1 blk_valid = 1'b0;
        wait_hv(k);
        check("held_latency", k, 67);
        take("held_digest");

        // Abort mid-block, then a clean block
        set_abc();
        send(1'b1);
        wait_widx(6'd30);
        abort = 1'b1;
        @(posedge sys_clk);
        #1 abort = 1'b0;
        @(negedge sys_clk);
        check("abort_idle", {blk_ready, core_en, hash_valid}, 3'b100);
        check("abort_chain_iv", chain_h, C_IV);
        exp_q.push_back(C_ABC);
        send(1'b1);
        wait_hv(k);
        take("post_abort_digest");

        // Reset during ROUND
        send(1'b1);
        wait_widx(6'd10);
        rst = 1'b1;
        @(posedge sys_clk);
        #1 rst = 1'b0;
        @(negedge sys_clk);
        check_reset_outputs("rst_round_ctrl");

        // Reset and abort together
        send(1'b1);
        wait_widx(6'd20);
        rst = 1'b1;
        abort = 1'b1;
        @(posedge sys_clk);
        #1 begin rst = 1'b0; abort = 1'b0; end
        @(negedge sys_clk);
        check_reset_outputs("rst_abort_ctrl");
        exp_q.push_back(C_ABC);
        send(1'b1);
        wait_hv(k);
        take("final_digest");

        check("init_en_overlap", both_hi, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
`default_nettype wire
